mem_arb_ctrl: RTL
=================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  NUM_CH, 2, number of requester channels (ch0 = data cache, ch1 = instruction cache); range 1..8.
  ADDR_W, 26, line address width.
  LINE_W, 128, line data width.
  LAT, 5, access latency in cycles; range 1..15.
  DEPTH, 1024, lines in the internal array; power of two.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  clock; all logic on the rising edge.
  reset  in  1  reset, synchronous, active-high.
  req_valid  in  NUM_CH  per-channel request pending.
  req_write  in  NUM_CH  per-channel 1 = write, 0 = read.
  req_addr  in  NUM_CH*ADDR_W  per-channel line address; channel c occupies bits [c*ADDR_W +: ADDR_W].
  req_wdata  in  NUM_CH*LINE_W  per-channel write line; channel c occupies bits [c*LINE_W +: LINE_W].
  req_ready  out  NUM_CH  one-cycle accept pulse to the granted channel.
  rsp_valid  out  NUM_CH  one-cycle completion pulse to the served channel.
  rsp_rdata  out  LINE_W  read line; on a write, the written line.
  busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have three states, IDLE, ACCESS and RESPOND, and one transaction SHALL be in flight at a time.
REQ-004 In IDLE, when any req_valid bit is high at a clock edge, the block SHALL:
  - grant exactly one channel;
  - latch that channel's write flag, address and write data;
  - load the latency counter with LAT-1;
  - move to ACCESS.
REQ-005 req_ready[g] SHALL be high for exactly the first ACCESS cycle, and all other req_ready bits SHALL be low.
REQ-006 A requester SHALL hold req_valid and its request fields stable until it sees req_ready.
REQ-007 Ungranted requests SHALL stay pending and SHALL NOT be lost.
REQ-008 In ACCESS, the counter SHALL decrement each cycle; in the cycle it equals 0, the block SHALL perform the array operation and move to RESPOND.
  - Write: array[idx] <= latched wdata.
  - Read: the read line is captured.
REQ-009 The array index SHALL be idx = addr[$clog2(DEPTH)-1:0]; upper address bits SHALL be ignored.
REQ-010 In RESPOND, the block SHALL hold rsp_valid[g] high for one cycle, present the read line on rsp_rdata (or the latched write data on a write), and return to IDLE.
REQ-011 rsp_valid SHALL rise exactly LAT cycles after the req_ready cycle.
REQ-012 Minimum issue interval per transaction SHALL be LAT+2 cycles.
REQ-013 rsp_rdata SHALL hold its value until the next RESPOND.
REQ-014 A read issued after a write completes to the same idx SHALL return the written data.
REQ-015 A request arriving while busy is high SHALL wait, and SHALL be arbitrated on the first IDLE edge.
REQ-016 When two or more channels request in the same IDLE edge, the block SHALL grant per REQ-021.

Reset
REQ-017 On reset, the FSM SHALL go to IDLE, the counter SHALL clear, and req_ready, rsp_valid and busy SHALL be 0.
REQ-018 On reset, rsp_rdata SHALL be cleared to 0, and the round-robin pointer SHALL be set to channel 0.
REQ-019 Reset in ACCESS or RESPOND SHALL abort the transaction: no array write, and no rsp_valid.
REQ-020 Array contents SHALL NOT be reset.

Configuration
REQ-021 Macro MEMCTL_RR_ARB_EN SHALL select the arbitration policy.
  - Defined: round-robin; the search starts at the channel after the last granted one and wraps NUM_CH-1 -> 0; the pointer updates on every grant.
  - Undefined: fixed priority; the lowest-index requesting channel wins, and the pointer logic is absent.

Verification
REQ-022 The bench SHALL cover these directed scenarios (LAT=5, NUM_CH=2 unless stated):
  - ch0 write addr 0x10, data 0xA5A5...A5 -> req_ready[0] in cycle N, rsp_valid[0] in cycle N+5; then a ch1 read of 0x10 -> rsp_rdata = 0xA5A5...A5.
  - ch0 and ch1 both request reads continuously -> RR defined: grants alternate 0,1,0,1; RR undefined: ch0 is granted every time and ch1 starves.
  - Address 0x400 with DEPTH=1024 -> aliases idx 0; a read returns the data written at 0x000.
  - Reset asserted 2 cycles into a ch0 write to 0x20 -> no rsp_valid; a later read of 0x20 returns the old contents.
  - ch1 request raised while busy -> held off; req_ready[1] occurs in the first ACCESS cycle after the block returns to IDLE, with no loss.
  - LAT=1 -> rsp_valid occurs 1 cycle after req_ready; back-to-back transactions are issued every 3 cycles.

Source files
------------

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: shares one single-port line array between NUM_CH requesters.
// One transaction is in flight at a time: IDLE (arbitrate) -> ACCESS (LAT
// cycles) -> RESPOND (one-cycle completion pulse) -> IDLE.
// Optional macro MEMCTL_RR_ARB_EN: round-robin arbitration. When it is not
// defined, the lowest-index requesting channel always wins.
module mem_arb_ctrl #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 26,
    parameter int LINE_W = 128,
    parameter int LAT    = 5,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LINE_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [LINE_W-1:0]        rsp_rdata,
    output logic                     busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [NUM_CH-1:0] req_ready_q, req_ready_d;
    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic              mem_we_s;
    logic              any_req_s;
    logic [CH_W-1:0]   pick_s;

    logic [LINE_W-1:0] mem [DEPTH];

`ifdef MEMCTL_RR_ARB_EN
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] cand_s;

    // Round-robin pick: search from the pointer upward, wrapping to channel 0.
    always_comb begin
        pick_s    = {CH_W{1'b0}};
        any_req_s = 1'b0;
        cand_s    = {CH_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!any_req_s && req_valid[cand_s]) begin
                any_req_s = 1'b1;
                pick_s    = cand_s;
            end else begin
                any_req_s = any_req_s;
            end
        end
        if ((state_q == IDLE) && any_req_s) begin
            rr_ptr_d = (int'(pick_s) == NUM_CH - 1) ? {CH_W{1'b0}} : pick_s + CH_W'(1'b1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer: next channel to search from, channel 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= {CH_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest-index requesting channel wins.
    always_comb begin
        pick_s    = {CH_W{1'b0}};
        any_req_s = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                any_req_s = 1'b1;
                pick_s    = CH_W'(k);
            end else begin
                any_req_s = any_req_s;
            end
        end
    end
`endif

    // Next-state and output decode for the IDLE/ACCESS/RESPOND controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_ready_d = {NUM_CH{1'b0}};
        rsp_valid_d = {NUM_CH{1'b0}};
        mem_we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d     = ACCESS;
                    gnt_d       = pick_s;
                    wr_d        = req_write[pick_s];
                    idx_d       = req_addr[int'(pick_s) * ADDR_W +: IDX_W];
                    wdata_d     = req_wdata[int'(pick_s) * LINE_W +: LINE_W];
                    cnt_d       = CNT_W'(LAT - 1);
                    req_ready_d = NUM_CH'(1) << pick_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d     = RESPOND;
                    mem_we_s    = wr_q;
                    rsp_valid_d = NUM_CH'(1) << gnt_q;
                    rdata_d     = wr_q ? wdata_q : mem[idx_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Controller state and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            gnt_q       <= {CH_W{1'b0}};
            wr_q        <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            wdata_q     <= {LINE_W{1'b0}};
            rdata_q     <= {LINE_W{1'b0}};
            req_ready_q <= {NUM_CH{1'b0}};
            rsp_valid_q <= {NUM_CH{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Line array write; contents survive reset, but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;

endmodule
